// File: rtl/spi_control.sv
// spi_control: SPI mode-0 slave giving a host read/write access to a
// register file of NREG words, CMD_W bits each. All SPI pins are
// oversampled in the i_clk domain. There is no SCLK clock domain.
//
// Ports:
//   i_clk  - system clock (48 MHz nominal)
//   i_rst  - asynchronous active-high reset
//   i_cs   - SPI chip select, active low
//   i_sclk - SPI clock, idle low (CPOL=0, CPHA=0)
//   i_mosi - data from host, MSB first
//   o_miso - data to host, MSB first, registered; 0 when not driving read data
//
// Command word: bit MSB = 1 for a read, 0 for a write. The low log2(NREG)
// bits are the start address. Following words stream with auto-increment.
//
// Build option: define SPI_CONTROL_ECHO_EN so that o_miso returns the
// previously captured MOSI bit during CMD and WR (1-bit-delayed echo).
module spi_control #(
  parameter int unsigned CMD_W = 16,
  parameter int unsigned NREG  = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_cs,
  input  logic i_sclk,
  input  logic i_mosi,
  output logic o_miso
);

  localparam int unsigned AW = $clog2(NREG);
  localparam int unsigned CW = $clog2(CMD_W);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_RD, S_WR} state_t;

  state_t state, state_next;

  logic [1:0]        cs_s, sclk_s, mosi_s;
  logic              sclk_d;
  logic              cs_hi, sclk_rise, sclk_fall, mosi_bit;
  logic [CW-1:0]     bit_cnt;
  logic [CMD_W-2:0]  shift_in;
  logic [CMD_W-1:0]  shift_out;
  logic [CMD_W-1:0]  rx_word;
  logic [AW-1:0]     addr;
  logic [AW-1:0]     addr_inc;
  logic              armed;
  logic              wr_pend;
  logic [CMD_W-1:0]  wr_word;
  logic [CMD_W-1:0]  regs [NREG];

  // Two-stage synchronizers plus SCLK edge detector
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cs_s   <= 2'b11;
      sclk_s <= 2'b00;
      mosi_s <= 2'b00;
      sclk_d <= 1'b0;
    end else begin
      cs_s   <= {cs_s[0], i_cs};
      sclk_s <= {sclk_s[0], i_sclk};
      mosi_s <= {mosi_s[0], i_mosi};
      sclk_d <= sclk_s[1];
    end
  end

  assign cs_hi     = cs_s[1];
  assign mosi_bit  = mosi_s[1];
  assign sclk_rise = sclk_s[1] & ~sclk_d;
  assign sclk_fall = ~sclk_s[1] & sclk_d;
  assign rx_word   = {shift_in, mosi_bit};
  assign addr_inc  = addr + AW'(1);

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (!cs_hi) state_next = S_CMD;
      S_CMD: begin
        if (cs_hi) state_next = S_IDLE;
        else if (sclk_rise && bit_cnt == CW'(CMD_W - 1))
          state_next = rx_word[CMD_W-1] ? S_RD : S_WR;
      end
      S_RD, S_WR: if (cs_hi) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: shifting, address, register file and MISO
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bit_cnt   <= '0;
      shift_in  <= '0;
      shift_out <= '0;
      addr      <= '0;
      armed     <= 1'b0;
      wr_pend   <= 1'b0;
      wr_word   <= '0;
      o_miso    <= 1'b0;
      for (int i = 0; i < int'(NREG); i++) regs[i] <= CMD_W'(32'hA500 + i);
    end else begin
      // A completed write word lands one cycle after its last rise
      wr_pend <= 1'b0;
      if (wr_pend) begin
        regs[addr] <= wr_word;
        addr       <= addr_inc;
      end

      if (cs_hi) begin
        bit_cnt  <= '0;
        shift_in <= '0;
        armed    <= 1'b0;
        o_miso   <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            bit_cnt <= '0;
            armed   <= 1'b0;
            o_miso  <= 1'b0;
          end
          S_CMD, S_WR: begin
            if (sclk_rise) begin
              shift_in <= rx_word[CMD_W-2:0];
              bit_cnt  <= bit_cnt + CW'(1);
              if (bit_cnt == CW'(CMD_W - 1)) begin
                bit_cnt <= '0;
                if (state == S_WR) begin
                  wr_pend <= 1'b1;
                  wr_word <= rx_word;
                end else begin
                  addr <= rx_word[AW-1:0];
                  if (rx_word[CMD_W-1]) begin
                    shift_out <= regs[rx_word[AW-1:0]];
                    o_miso    <= regs[rx_word[AW-1:0]][CMD_W-1];
                  end
                end
              end
            end
`ifdef SPI_CONTROL_ECHO_EN
            else if (sclk_fall) o_miso <= shift_in[0];
`endif
          end
          S_RD: begin
            // armed blocks the fall that trails the command's last rise,
            // so bit MSB stays on the line for the host's first sample
            if (sclk_rise) begin
              bit_cnt <= bit_cnt + CW'(1);
              armed   <= 1'b1;
            end else if (sclk_fall && armed) begin
              armed <= 1'b0;
              if (bit_cnt == '0) begin
                addr      <= addr_inc;
                shift_out <= regs[addr_inc];
                o_miso    <= regs[addr_inc][CMD_W-1];
              end else begin
                shift_out <= {shift_out[CMD_W-2:0], 1'b0};
                o_miso    <= shift_out[CMD_W-2];
              end
            end
          end
          default: o_miso <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_control.sv
module tb_spi_control;

  logic i_clk = 1'b0;
  logic i_rst, i_cs, i_sclk, i_mosi;
  logic o_miso;

  int tests = 0;
  int fails = 0;

  logic [15:0] model [16];
  logic [15:0] exp_q [$];
  logic        echo_prev;

  spi_control #(.CMD_W(16), .NREG(16)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_cs  (i_cs),
    .i_sclk(i_sclk),
    .i_mosi(i_mosi),
    .o_miso(o_miso)
  );

  always #5 i_clk = ~i_clk;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) model[i] = 16'hA500 + 16'(i);
  endtask

  // Host sends w (first nbits, MSB first) and samples MISO before each rise
  task automatic xfer(input logic [15:0] w, input int nbits, output logic [15:0] r);
    r = '0;
    for (int i = 15; i >= 16 - nbits; i--) begin
      i_mosi = w[i];
      wait_clk(8);
      r[i] = o_miso;
      i_sclk = 1'b1;
      wait_clk(8);
      i_sclk = 1'b0;
    end
  endtask

  task automatic cs_low();
    i_cs = 1'b0;
    echo_prev = 1'b0;
    wait_clk(8);
  endtask

  task automatic cs_high(input string tag);
    wait_clk(8);
    i_cs = 1'b1;
    i_mosi = 1'b0;
    wait_clk(8);
    check(tag, {15'd0, o_miso}, 16'd0);
  endtask

  // Command or write-data word: MISO is either 0 or the delayed echo
  task automatic send_word(input string tag, input logic [15:0] w);
    logic [15:0] r;
`ifdef SPI_CONTROL_ECHO_EN
    exp_q.push_back({echo_prev, w[15:1]});
    echo_prev = w[0];
`else
    exp_q.push_back(16'h0000);
`endif
    xfer(w, 16, r);
    check(tag, r, exp_q.pop_front());
  endtask

  task automatic write_word(input string tag, input int a, input logic [15:0] d);
    model[a] = d;
    send_word(tag, d);
  endtask

  task automatic read_word(input string tag, input int a);
    logic [15:0] r;
    exp_q.push_back(model[a]);
    xfer(16'h5A5A, 16, r);
    check(tag, r, exp_q.pop_front());
  endtask

  initial begin
    logic [15:0] dummy;
    i_rst = 1'b1; i_cs = 1'b1; i_sclk = 1'b0; i_mosi = 1'b0;
    echo_prev = 1'b0;
    model_reset();
    wait_clk(4);
    check("miso_in_reset", {15'd0, o_miso}, 16'd0);
    i_rst = 1'b0;
    wait_clk(8);
    check("miso_after_reset", {15'd0, o_miso}, 16'd0);

    // Read reset value of register 3
    cs_low();
    check("miso_cs_low", {15'd0, o_miso}, 16'd0);
    send_word("cmd_rd3", 16'h8003);
    read_word("rd3", 3);
    cs_high("idle_after_rd3");

    // Write 0x1234 to register 2, read it back
    cs_low();
    send_word("cmd_wr2", 16'h0002);
    write_word("wr2", 2, 16'h1234);
    cs_high("idle_after_wr2");
    cs_low();
    send_word("cmd_rd2", 16'h8002);
    read_word("rd2", 2);
    cs_high("idle_after_rd2");

    // Streaming read across the address wrap
    cs_low();
    send_word("cmd_rd15", 16'h800F);
    read_word("rd15", 15);
    read_word("rd0_wrap", 0);
    cs_high("idle_after_wrap");

    // Streaming write to 6 and 7, with ignored command bits set
    cs_low();
    send_word("cmd_wr6", 16'h7FF6);
    write_word("wr6", 6, 16'hBEEF);
    write_word("wr7", 7, 16'hCAFE);
    cs_high("idle_after_wr67");
    cs_low();
    send_word("cmd_rd6", 16'h8006);
    read_word("rd6", 6);
    read_word("rd7", 7);
    read_word("rd8", 8);
    cs_high("idle_after_rd678");

    // Partial write word is discarded
    cs_low();
    send_word("cmd_wr4", 16'h0004);
    xfer(16'hFFFF, 8, dummy);
    cs_high("idle_after_partial");
    cs_low();
    send_word("cmd_rd4", 16'h8004);
    read_word("rd4_unchanged", 4);
    cs_high("idle_after_rd4");

    // Reset in the middle of a read aborts at once and restores registers
    cs_low();
    send_word("cmd_rd15b", 16'h800F);
    wait_clk(4);
    check("rd15_msb_driven", {15'd0, o_miso}, 16'd1);
    i_rst = 1'b1;
    #1;
    check("miso_reset_abort", {15'd0, o_miso}, 16'd0);
    model_reset();
    i_cs = 1'b1;
    wait_clk(4);
    i_rst = 1'b0;
    wait_clk(8);
    cs_low();
    send_word("cmd_rd2_post", 16'h8002);
    read_word("rd2_post_reset", 2);
    cs_high("idle_after_post");

    // Echo command pattern (all zero without echo build)
    cs_low();
    send_word("cmd_echo", 16'hF001);
    read_word("rd1_after_echo", 1);
    cs_high("idle_final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
